// File: rtl/seq_priority_decoder_if.sv
// Handshake/output bundle for seq_priority_decoder.
// SEQ_DEC_SEEN_MASK_EN adds the seen_clr/seen sticky-mask signals.
interface seq_priority_decoder_if #(
   parameter int CODE_W = 3
);
   localparam int OUT_W = 2 ** CODE_W;

   logic              in_valid;
   logic              in_ready;
   logic [CODE_W-1:0] code;
   logic [OUT_W-1:0]  dout;
   logic              out_valid;
   logic              busy;
`ifdef SEQ_DEC_SEEN_MASK_EN
   logic              seen_clr;
   logic [OUT_W-1:0]  seen;

   modport master (
      output in_valid, code, seen_clr,
      input  in_ready, dout, out_valid, busy, seen
   );
   modport slave (
      input  in_valid, code, seen_clr,
      output in_ready, dout, out_valid, busy, seen
   );
`else
   modport master (
      output in_valid, code,
      input  in_ready, dout, out_valid, busy
   );
   modport slave (
      input  in_valid, code,
      output in_ready, dout, out_valid, busy
   );
`endif
endinterface

// File: rtl/seq_priority_decoder.sv
// Registered CODE_W-to-2**CODE_W decoder holding each one-hot line HOLD_CYCLES cycles.
// Optional sticky seen mask enabled by defining SEQ_DEC_SEEN_MASK_EN.
module seq_priority_decoder #(
   parameter int CODE_W      = 3,
   parameter int HOLD_CYCLES = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   seq_priority_decoder_if.slave bus
);
   localparam int OUT_W = 2 ** CODE_W;
   localparam int CNT_W = $clog2(HOLD_CYCLES) + 1;

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] HOLD = 1'b1;

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [OUT_W-1:0] ONE      = OUT_W'(1);

   logic [0:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [OUT_W-1:0] dout_q, dout_d;
   logic             ready;
   logic             accept;

   // Ready depends only on registered state, never on in_valid.
   assign ready  = (state_q == IDLE) || (cnt_q == '0);
   assign accept = bus.in_valid && ready;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dout_d  = dout_q;
      if (accept) begin
         state_d = HOLD;
         cnt_d   = CNT_LOAD;
         dout_d  = ONE << bus.code;
      end else if (state_q == HOLD) begin
         if (cnt_q == '0) begin
            state_d = IDLE;
            dout_d  = '0;
         end else begin
            cnt_d = cnt_q - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         dout_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dout_q  <= dout_d;
      end
   end

   assign bus.in_ready  = ready;
   assign bus.dout      = dout_q;
   assign bus.out_valid = |dout_q;
   assign bus.busy      = (state_q == HOLD);

`ifdef SEQ_DEC_SEEN_MASK_EN
   logic [OUT_W-1:0] seen_q, seen_d;

   // Clear applies first so a coincident acceptance survives it.
   always_comb begin
      seen_d = bus.seen_clr ? '0 : seen_q;
      if (accept) seen_d = seen_d | (ONE << bus.code);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) seen_q <= '0;
      else        seen_q <= seen_d;
   end

   assign bus.seen = seen_q;
`endif
endmodule

// File: tb/tb_seq_priority_decoder.sv
// Randomised self-checking bench: HOLD_CYCLES=4 and HOLD_CYCLES=1 decoders
// driven in lockstep, each compared against a remaining-cycles reference model.
module tb_seq_priority_decoder;
   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   seq_priority_decoder_if #(.CODE_W(3)) b4 ();
   seq_priority_decoder_if #(.CODE_W(3)) b1 ();

   seq_priority_decoder #(.CODE_W(3), .HOLD_CYCLES(4)) dut4 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b4)
   );

   seq_priority_decoder #(.CODE_W(3), .HOLD_CYCLES(1)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b1)
   );

   int unsigned nvec = 0;
   int unsigned nerr = 0;

   // Reference model: a hold is "remaining cycles" of the current value.
   int          hc   [2] = '{4, 1};
   int          rem  [2];
   logic [7:0]  val  [2];
   logic [7:0]  seenm[2];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         rem[i]   = 0;
         val[i]   = 8'h00;
         seenm[i] = 8'h00;
      end
   endtask

   task automatic check_all(input string tag);
      logic [7:0] ed;
      for (int i = 0; i < 2; i++) begin
         ed = (rem[i] > 0) ? val[i] : 8'h00;
         if (i == 0) begin
            chk({tag, "/h4 dout"},  32'(b4.dout), 32'(ed));
            chk({tag, "/h4 ovld"},  32'(b4.out_valid), 32'(ed != 8'h00));
            chk({tag, "/h4 busy"},  32'(b4.busy), 32'(rem[i] > 0));
            chk({tag, "/h4 rdy"},   32'(b4.in_ready), 32'(rem[i] <= 1));
            chk({tag, "/h4 1hot"},  32'($onehot0(b4.dout)), 32'd1);
`ifdef SEQ_DEC_SEEN_MASK_EN
            chk({tag, "/h4 seen"},  32'(b4.seen), 32'(seenm[i]));
`endif
         end else begin
            chk({tag, "/h1 dout"},  32'(b1.dout), 32'(ed));
            chk({tag, "/h1 ovld"},  32'(b1.out_valid), 32'(ed != 8'h00));
            chk({tag, "/h1 busy"},  32'(b1.busy), 32'(rem[i] > 0));
            chk({tag, "/h1 rdy"},   32'(b1.in_ready), 32'(rem[i] <= 1));
`ifdef SEQ_DEC_SEEN_MASK_EN
            chk({tag, "/h1 seen"},  32'(b1.seen), 32'(seenm[i]));
`endif
         end
      end
   endtask

   // Called at a negedge: apply inputs, check, advance one rising edge.
   task automatic cyc(input string tag, input logic v, input logic [2:0] c, input logic clr);
      logic acc;
      b4.in_valid = v;  b4.code = c;
      b1.in_valid = v;  b1.code = c;
`ifdef SEQ_DEC_SEEN_MASK_EN
      b4.seen_clr = clr;
      b1.seen_clr = clr;
`endif
      #1;
      check_all(tag);
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         acc = v && (rem[i] <= 1);
         if (clr) seenm[i] = 8'h00;
         if (acc) begin
            val[i]   = 8'h01 << c;
            rem[i]   = hc[i];
            seenm[i] = seenm[i] | (8'h01 << c);
         end else if (rem[i] > 0) begin
            rem[i]--;
         end
      end
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      b4.in_valid = 1'b0;  b4.code = '0;
      b1.in_valid = 1'b0;  b1.code = '0;
`ifdef SEQ_DEC_SEEN_MASK_EN
      b4.seen_clr = 1'b0;
      b1.seen_clr = 1'b0;
`endif
      model_reset();
      @(negedge clk);
      #1;
      check_all("in_reset");
      @(negedge clk);
      rst_n = 1'b1;

      for (int n = 0; n < 10; n++) cyc("idle", 1'b0, 3'd0, 1'b0);

      cyc("single", 1'b1, 3'd5, 1'b0);
      for (int n = 0; n < 5; n++) cyc("single", 1'b0, 3'd0, 1'b0);

      cyc("b2b", 1'b1, 3'd7, 1'b0);
      for (int n = 0; n < 8; n++) cyc("b2b", 1'b1, 3'd0, 1'b0);
      for (int n = 0; n < 5; n++) cyc("b2b", 1'b0, 3'd0, 1'b0);

      for (int c = 0; c < 8; c++) cyc("sweep", 1'b1, 3'(c), 1'b0);
      for (int n = 0; n < 5; n++) cyc("sweep", 1'b0, 3'd0, 1'b0);

      cyc("seen", 1'b1, 3'd2, 1'b0);
      for (int n = 0; n < 4; n++) cyc("seen", 1'b0, 3'd0, 1'b0);
      cyc("seen", 1'b1, 3'd5, 1'b0);
      for (int n = 0; n < 4; n++) cyc("seen", 1'b0, 3'd0, 1'b0);
      cyc("seen_clr", 1'b1, 3'd0, 1'b1);
      for (int n = 0; n < 4; n++) cyc("seen_clr", 1'b0, 3'd0, 1'b0);

      cyc("arst", 1'b1, 3'd6, 1'b0);
      cyc("arst", 1'b0, 3'd0, 1'b0);
      cyc("arst", 1'b0, 3'd0, 1'b0);
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      check_all("arst_now");
      @(negedge clk);
      rst_n = 1'b1;
      cyc("arst_rel", 1'b1, 3'd1, 1'b0);
      for (int n = 0; n < 5; n++) cyc("arst_rel", 1'b0, 3'd0, 1'b0);

      for (int n = 0; n < 400; n++)
         cyc("rand", 1'($urandom_range(0, 3) != 0), 3'($urandom), 1'($urandom_range(0, 15) == 0));
      for (int n = 0; n < 5; n++) cyc("drain", 1'b0, 3'd0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule

// File: doc/seq_priority_decoder.md
Name: seq_priority_decoder

Overview:
- Registered 3-to-8 decoder: the receive-side counterpart of the team's 8-to-3 priority encoder.
- Accepts an encoded index with a valid/ready handshake.
- Drives exactly one of 2**CODE_W one-hot lines for HOLD_CYCLES clock cycles, then returns to idle.
- Sits downstream of the encoder, turning an encoded request back into a timed one-hot strobe or grant.

Parameters:
- CODE_W, 3: width of the encoded index; output width OUT_W = 2**CODE_W (8 by default).
- HOLD_CYCLES, 4: number of cycles each decoded line stays asserted; legal range 1..255; counter width is clog2(HOLD_CYCLES)+1.

Ports:
- clk  input  1  sole clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  code is valid this cycle.
- in_ready  output  1  block can accept a code this cycle.
- code  input  CODE_W  encoded index; MSB is the encoder's "a" bit, LSB is its "c" bit.
- dout  output  OUT_W  one-hot decoded lines; dout[i] is high when the accepted code equals i.
- out_valid  output  1  high whenever dout is non-zero.
- busy  output  1  high in the HOLD state.

Behaviour:
- Single clock; reset is asynchronous and active-low.
- Reset values: dout=0, out_valid=0, busy=0, state=IDLE, hold counter=0, captured code=0. in_ready is 1 while reset is low and immediately after reset.
- States: IDLE and HOLD.
- Acceptance: a code is accepted on a rising edge where in_valid && in_ready. code is sampled on that edge only; code changes outside acceptance are ignored.
- IDLE:
  - in_ready=1, dout=0, busy=0.
  - On acceptance: go to HOLD, load counter with HOLD_CYCLES-1, register dout = 1<<code.
- HOLD:
  - dout holds the captured one-hot value, busy=1, out_valid=1.
  - The counter decrements each cycle.
  - in_ready is 1 only when counter==0, i.e. the last hold cycle; it is combinational from state and counter, with no path from in_valid.
- End of hold, counter==0 with no acceptance: next state IDLE, dout=0.
- End of hold, counter==0 with acceptance (back-to-back): stay in HOLD, reload counter to HOLD_CYCLES-1, dout takes the new one-hot value on the same edge. There are no idle gap cycles.
- Latency: the code accepted at edge k appears on dout from edge k and stays for exactly HOLD_CYCLES cycles, through the cycle before edge k+HOLD_CYCLES.
- HOLD_CYCLES=1:
  - in_ready stays permanently 1.
  - dout follows each accepted code for one cycle, then returns to 0 if in_valid is low.
- in_valid while in_ready=0: not accepted and not queued; the upstream must hold in_valid and code until in_ready.
- Invariant: dout is always zero or exactly one-hot. out_valid == |dout at all times.
- Reset mid-operation:
  - Asserting rst_n=0 asynchronously clears all outputs and state to the reset values, including during HOLD.
  - The code in flight is discarded.
  - After release, the first acceptance is possible on the first rising edge.
- No "no-input" code exists: the encoder's all-inputs-low condition must be expressed upstream by holding in_valid=0. The decoder never drives z.

Optional Feature:
- Macro: SEQ_DEC_SEEN_MASK_EN.
- When defined, two extra ports are added:
  - seen_clr  input  1  synchronous clear of the sticky mask.
  - seen  output  OUT_W  sticky mask.
- seen bit i sets on the edge that accepts code i and stays set until seen_clr or reset. Reset value is 0.
- If seen_clr and an acceptance coincide, the clear takes effect first and the newly accepted bit is set, so seen == 1<<code afterwards.
- When not defined, the ports and register are absent and the behaviour is otherwise identical.

Test Plan:
- Reset then idle, no in_valid for 10 cycles -> dout=0x00, out_valid=0, busy=0, in_ready=1 throughout.
- Single accept with HOLD_CYCLES=4:
  - Stimulus: code=3'b101, in_valid for one cycle.
  - Required: dout=0x20 for exactly 4 cycles; in_ready=0 for the first 3 of those cycles and 1 on the 4th; then dout=0x00, IDLE.
- Back-to-back, HOLD_CYCLES=4:
  - Stimulus: in_valid held high with code=7, switched to code=0 after the first acceptance.
  - Required: dout=0x80 for 4 cycles, then 0x01 for 4 cycles, with no zero cycle between.
- Sweep all codes 0..7 with HOLD_CYCLES=1 -> dout steps 0x01,0x02,...,0x80 on consecutive cycles, always one-hot.
- Async reset in HOLD:
  - Stimulus: accept code=6, drop rst_n after 2 cycles, asynchronous to clk.
  - Required: dout=0x00, busy=0 immediately; after release, accepting code=1 gives dout=0x02.
- SEQ_DEC_SEEN_MASK_EN defined:
  - Stimulus: accept codes 2 and 5, then pulse seen_clr together with accepting code 0.
  - Required: seen=0x24 before the clear, then seen=0x01.
